// File: rtl/adc_cap_pkg.sv
// Shared types and widths for the ADC capture packer.
package adc_cap_pkg;

  localparam int SAMPLE_W       = 16;
  localparam int LANES          = 4;
  localparam int IN_W           = SAMPLE_W * LANES;
  localparam int OUT_W          = 2 * IN_W;
  localparam int BYTES_PER_BEAT = OUT_W / 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARMED   = 3'd1,
    CAPTURE = 3'd2,
    DRAIN   = 3'd3,
    DONE    = 3'd4
  } cap_state_e;

endpackage

// File: rtl/adc_capture_packer_fifo.sv
// Single-clock beat FIFO with a registered output stage.
// Occupancy counts the output register, so DEPTH beats fit in total.
module axis_sync_fifo #(
  parameter int WIDTH = 129,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  output logic             empty,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      mem_cnt_q, mem_cnt_d, occ;
  logic             out_vld_q, out_vld_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             wr_en, pop, load;

  // Pointer/count bookkeeping and output-stage refill.
  always_comb begin
    occ        = mem_cnt_q + {{AW{1'b0}}, out_vld_q};
    full       = (occ == (AW+1)'(DEPTH));
    empty      = (mem_cnt_q == '0) && !out_vld_q;
    wr_en      = push && !full;
    pop        = out_vld_q && out_ready;
    load       = (mem_cnt_q != '0) && (!out_vld_q || pop);
    wr_ptr_d   = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = load ? rd_ptr_q + 1'b1 : rd_ptr_q;
    mem_cnt_d  = mem_cnt_q + {{AW{1'b0}}, wr_en} - {{AW{1'b0}}, load};
    out_vld_d  = load || (out_vld_q && !pop);
    out_data_d = load ? mem_q[rd_ptr_q] : out_data_q;
  end

  // Storage array; contents need no reset since the count guards reads.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= push_data;
  end

  // Control registers; flush behaves as a local reset.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      mem_cnt_q  <= '0;
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      mem_cnt_q  <= mem_cnt_d;
      out_vld_q  <= out_vld_d;
      out_data_q <= out_data_d;
    end
  end

  assign out_valid = out_vld_q;
  assign out_data  = out_data_q;

endmodule

// File: rtl/adc_capture_packer.sv
// Triggered ADC capture: packs 64-bit words into 128-bit AXIS beats.
// Optional build macro TEST_PATTERN_EN replaces ADC data with a lane ramp.
//
// state   | meaning
// IDLE    | waiting for arm
// ARMED   | cap_size latched, waiting for trigger rising edge
// CAPTURE | packing words until target beat count produced
// DRAIN   | waiting for FIFO and in-flight beat to empty
// DONE    | capture complete, cap_done asserted
module adc_capture_packer
  import adc_cap_pkg::*;
#(
  parameter int FIFO_DEPTH = 16
) (
  input  logic             axi_aclk,
  input  logic             axi_rst,
  input  logic [IN_W-1:0]  s_adc_tdata,
  input  logic             s_adc_tvalid,
  input  logic             trig_in,
  input  logic             arm,
  input  logic             write_reset,
  input  logic [31:0]      cap_size,
  output logic [OUT_W-1:0] m_axis_tdata,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic             m_axis_tlast,
  output logic             capturing,
  output logic             cap_done,
  output logic             overflow,
  output logic [31:0]      beat_count
);

  cap_state_e       state_q, state_d;
  logic             trig_q;
  logic [31:0]      cap_size_q, cap_size_d;
  logic [31:0]      remaining_q, remaining_d;
  logic             phase_q, phase_d;
  logic [IN_W-1:0]  low_q, low_d;
  logic             beat_vld_q, beat_vld_d;
  logic             beat_last_q, beat_last_d;
  logic [OUT_W-1:0] beat_q, beat_d;
  logic [31:0]      beat_count_q, beat_count_d;
  logic             overflow_q, overflow_d;
  logic             cap_done_q, cap_done_d;

  logic [31:0]      target_beats;
  logic             trig_edge, arm_ok, accept, beat_fire;
  logic [IN_W-1:0]  word;
  logic             fifo_full, fifo_empty;
  logic [OUT_W:0]   fifo_out;

`ifdef TEST_PATTERN_EN
  logic [SAMPLE_W-1:0] ramp_q, ramp_d;

  // Ramp source: lane i carries ramp+i, advancing on every valid cycle.
  always_comb begin
    word = '0;
    for (int i = 0; i < LANES; i++) begin
      word[i*SAMPLE_W +: SAMPLE_W] = ramp_q + SAMPLE_W'(i);
    end
    ramp_d = ramp_q;
    if (arm_ok)            ramp_d = '0;
    else if (s_adc_tvalid) ramp_d = ramp_q + SAMPLE_W'(LANES);
  end

  // Ramp register, restarts on reset/abort.
  always_ff @(posedge axi_aclk) begin
    if (axi_rst || write_reset) ramp_q <= '0;
    else                        ramp_q <= ramp_d;
  end
`else
  assign word = s_adc_tdata;
`endif

  // Next-state, packing and status computation.
  always_comb begin
    target_beats = cap_size_q >> 4;
    trig_edge    = trig_in && !trig_q;
    arm_ok       = arm && (state_q == IDLE || state_q == DONE);
    accept       = s_adc_tvalid &&
                   (state_q == CAPTURE ||
                    (state_q == ARMED && trig_edge && target_beats != '0));
    beat_fire    = accept && phase_q;

    state_d      = state_q;
    cap_size_d   = cap_size_q;
    remaining_d  = remaining_q;
    phase_d      = accept ? !phase_q : phase_q;
    low_d        = (accept && !phase_q) ? word : low_q;
    beat_vld_d   = beat_fire;
    beat_last_d  = beat_fire && (remaining_q == 32'd1);
    beat_d       = beat_fire ? {word, low_q} : beat_q;
    beat_count_d = beat_count_q;
    overflow_d   = overflow_q;
    cap_done_d   = (state_q == DONE) && !arm_ok;

    if (beat_vld_q) begin
      if (fifo_full)                  overflow_d   = 1'b1;
      else if (beat_count_q != '1)    beat_count_d = beat_count_q + 32'd1;
    end

    case (state_q)
      IDLE, DONE: if (arm_ok) state_d = ARMED;
      ARMED: begin
        if (trig_edge) begin
          remaining_d = target_beats;
          state_d     = (target_beats == '0) ? DONE : CAPTURE;
        end
      end
      CAPTURE: begin
        if (beat_fire) begin
          remaining_d = remaining_q - 32'd1;
          if (remaining_q == 32'd1) state_d = DRAIN;
        end
      end
      DRAIN: if (fifo_empty && !beat_vld_q) state_d = DONE;
      default: state_d = IDLE;
    endcase

    if (arm_ok) begin
      cap_size_d   = cap_size;
      phase_d      = 1'b0;
      beat_count_d = '0;
      overflow_d   = 1'b0;
    end
  end

  // Control state; write_reset clears everything except the latched size.
  always_ff @(posedge axi_aclk) begin
    if (axi_rst || write_reset) begin
      state_q      <= IDLE;
      trig_q       <= 1'b0;
      remaining_q  <= '0;
      phase_q      <= 1'b0;
      low_q        <= '0;
      beat_vld_q   <= 1'b0;
      beat_last_q  <= 1'b0;
      beat_q       <= '0;
      beat_count_q <= '0;
      overflow_q   <= 1'b0;
      cap_done_q   <= 1'b0;
      if (axi_rst) cap_size_q <= '0;
    end else begin
      state_q      <= state_d;
      trig_q       <= trig_in;
      cap_size_q   <= cap_size_d;
      remaining_q  <= remaining_d;
      phase_q      <= phase_d;
      low_q        <= low_d;
      beat_vld_q   <= beat_vld_d;
      beat_last_q  <= beat_last_d;
      beat_q       <= beat_d;
      beat_count_q <= beat_count_d;
      overflow_q   <= overflow_d;
      cap_done_q   <= cap_done_d;
    end
  end

  axis_sync_fifo #(
    .WIDTH (OUT_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (axi_aclk),
    .rst       (axi_rst),
    .flush     (write_reset),
    .push      (beat_vld_q),
    .push_data ({beat_last_q, beat_q}),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .out_valid (m_axis_tvalid),
    .out_ready (m_axis_tready),
    .out_data  (fifo_out)
  );

  assign m_axis_tdata = fifo_out[OUT_W-1:0];
  assign m_axis_tlast = fifo_out[OUT_W];
  assign capturing    = (state_q == CAPTURE);
  assign cap_done     = cap_done_q;
  assign overflow     = overflow_q;
  assign beat_count   = beat_count_q;

endmodule

// File: tb/tb_adc_capture_packer.sv
// Scoreboard bench for adc_capture_packer: stimulus pushes expected beats,
// an independent monitor pops and compares on every AXIS handshake.
module tb_adc_capture_packer;

  logic         clk = 1'b0;
  logic         rst;
  logic [63:0]  adc_data;
  logic         adc_valid;
  logic         trig;
  logic         arm;
  logic         wr_rst;
  logic [31:0]  cap_size;
  logic [127:0] tdata;
  logic         tvalid;
  logic         tready;
  logic         tlast;
  logic         capturing;
  logic         cap_done;
  logic         overflow;
  logic [31:0]  beat_count;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int last_hs_cyc = 0;
  int done_cyc    = 0;

  logic [127:0] exp_data_q[$];
  logic         exp_last_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  adc_capture_packer dut (
    .axi_aclk      (clk),
    .axi_rst       (rst),
    .s_adc_tdata   (adc_data),
    .s_adc_tvalid  (adc_valid),
    .trig_in       (trig),
    .arm           (arm),
    .write_reset   (wr_rst),
    .cap_size      (cap_size),
    .m_axis_tdata  (tdata),
    .m_axis_tvalid (tvalid),
    .m_axis_tready (tready),
    .m_axis_tlast  (tlast),
    .capturing     (capturing),
    .cap_done      (cap_done),
    .overflow      (overflow),
    .beat_count    (beat_count)
  );

  function automatic logic [63:0] word(input int k);
    logic [63:0] w;
    for (int i = 0; i < 4; i++) w[i*16 +: 16] = 16'(4*k + i);
    return w;
  endfunction

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic check_range(input string name, input int got, input int lo, input int hi);
    n_checks++;
    if (got >= lo && got <= hi) n_pass++;
    else $display("FAIL %s: got %0d expected %0d..%0d", name, got, lo, hi);
  endtask

  task automatic expect_beats(input int first, input int n, input int last_idx);
    for (int b = first; b < first + n; b++) begin
      exp_data_q.push_back({word(2*b+1), word(2*b)});
      exp_last_q.push_back(b == last_idx);
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive n words; the trigger level is already high on the first one.
  task automatic send_words(input int n, input bit toggle);
    for (int k = 0; k < n; k++) begin
`ifdef TEST_PATTERN_EN
      adc_data = 64'hBAD0_BAD0_BAD0_BAD0 ^ 64'(k);
`else
      adc_data = word(k);
`endif
      adc_valid = 1'b1;
      @(negedge clk);
      if (toggle) begin
        adc_data  = 64'hDEAD_BEEF_DEAD_BEEF;
        adc_valid = 1'b0;
        @(negedge clk);
      end
    end
    adc_valid = 1'b0;
    adc_data  = 64'hDEAD_BEEF_DEAD_BEEF;
  endtask

  task automatic do_arm(input logic [31:0] size);
    arm = 1'b1; cap_size = size;
    @(negedge clk);
    arm = 1'b0;
    trig = 1'b1;
  endtask

  task automatic wait_done(input string name, input int bound);
    for (int i = 0; i < bound; i++) begin
      if (cap_done) break;
      @(negedge clk);
    end
    done_cyc = cyc;
    check(name, cap_done, 1'b1);
  endtask

  // Monitor: compares each handshake against the scoreboard and checks
  // that a stalled beat stays put.
  initial begin
    logic         prev_stall = 1'b0;
    logic         prev_wr    = 1'b0;
    logic [127:0] prev_data  = '0;
    logic         prev_last  = 1'b0;
    forever begin
      @(negedge clk); #2;
      if (prev_stall && !prev_wr && !rst) begin
        check("stall_tvalid", tvalid, 1'b1);
        check("stall_tdata", {tdata[126:0], tlast}, {prev_data[126:0], prev_last});
      end
      if (tvalid && tready) begin
        if (exp_data_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_beat: got %h expected none", tdata);
        end else begin
          logic [127:0] ed;
          logic         el;
          ed = exp_data_q.pop_front();
          el = exp_last_q.pop_front();
          check("beat_data", tdata, ed);
          check("beat_last", tlast, el);
          if (el) last_hs_cyc = cyc;
        end
      end
      prev_stall = tvalid && !tready;
      prev_wr    = wr_rst;
      prev_data  = tdata;
      prev_last  = tlast;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; adc_data = '0; adc_valid = 1'b0; trig = 1'b0;
    arm = 1'b0; wr_rst = 1'b0; cap_size = '0; tready = 1'b1;
    ticks(3);
    rst = 1'b0;
    ticks(1);
    check("rst_tvalid", tvalid, 1'b0);
    check("rst_cap_done", cap_done, 1'b0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_beat_count", beat_count, 32'd0);
    check("rst_capturing", capturing, 1'b0);

    // 64 bytes, continuous valid, tready high.
    expect_beats(0, 4, 3);
    do_arm(32'd64);
    send_words(8, 1'b0);
    wait_done("t1_done", 40);
    check_range("t1_done_latency", done_cyc - last_hs_cyc, 2, 3);
    check("t1_overflow", overflow, 1'b0);
    check("t1_beat_count", beat_count, 32'd4);
    check("t1_sb_empty", exp_data_q.size(), 0);
    trig = 1'b0; ticks(2);

    // Same capture with valid toggling every cycle.
    expect_beats(0, 4, 3);
    do_arm(32'd64);
    check("t2_cap_done_cleared", cap_done, 1'b0);
    send_words(8, 1'b1);
    wait_done("t2_done", 40);
    check("t2_beat_count", beat_count, 32'd4);
    check("t2_sb_empty", exp_data_q.size(), 0);
    trig = 1'b0; ticks(2);

    // 512 bytes with downstream stalled: first 16 fit, rest dropped, no tlast.
    tready = 1'b0;
    expect_beats(0, 16, -1);
    do_arm(32'd512);
    send_words(64, 1'b0);
    ticks(16);
    check("t3_overflow", overflow, 1'b1);
    check("t3_beat_count", beat_count, 32'd16);
    check("t3_tvalid_held", tvalid, 1'b1);
    check("t3_not_capturing", capturing, 1'b0);
    tready = 1'b1;
    wait_done("t3_done", 60);
    check("t3_sb_empty", exp_data_q.size(), 0);
    trig = 1'b0; ticks(2);

    // write_reset mid-capture with 5 beats queued.
    tready = 1'b0;
    do_arm(32'd512);
    send_words(10, 1'b0);
    ticks(3);
    check("t4_capturing", capturing, 1'b1);
    check("t4_beat_count", beat_count, 32'd5);
    check("t4_tvalid", tvalid, 1'b1);
    trig = 1'b0;
    wr_rst = 1'b1;
    ticks(1);
    wr_rst = 1'b0;
    check("t4_wr_tvalid", tvalid, 1'b0);
    check("t4_wr_capturing", capturing, 1'b0);
    check("t4_wr_beat_count", beat_count, 32'd0);
    check("t4_wr_cap_done", cap_done, 1'b0);
    tready = 1'b1;
    ticks(5);
    check("t4_idle_tvalid", tvalid, 1'b0);

    // Below one beat: trigger goes straight to DONE.
    do_arm(32'd10);
    send_words(4, 1'b0);
    wait_done("t5_done", 10);
    check("t5_tvalid", tvalid, 1'b0);
    check("t5_beat_count", beat_count, 32'd0);
    check("t5_capturing", capturing, 1'b0);
    trig = 1'b0; ticks(2);

    // 32 bytes: lanes 0..15 in two beats; a mid-capture arm must be ignored.
    expect_beats(0, 2, 1);
    do_arm(32'd32);
    fork
      send_words(8, 1'b0);
      begin ticks(2); arm = 1'b1; cap_size = 32'd512; ticks(1); arm = 1'b0; end
    join
    wait_done("t6_done", 30);
    check("t6_beat_count", beat_count, 32'd2);
    check("t6_sb_empty", exp_data_q.size(), 0);
    trig = 1'b0; ticks(4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
